// File: rtl/dtree_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dtree_seq_ctrl
// Purpose  : Sequential decision-tree classifier. A programmable node table
//            is walked one node per cycle with a single shared comparator
//            until a leaf, an invalid feature index or the loop guard ends
//            the walk. The result is held until the consumer accepts it.
// Ports    : clk, rst_n              - clock, async active-low reset
//            cfg_we_i/addr_i/data_i  - node-table write port (IDLE only)
//            cfg_ready_o             - table may be written
//            in_valid_i/in_ready_o   - feature-vector handshake
//            feat_in_i               - packed 8-bit features, k at [8k+7:8k]
//            out_valid_o/out_ready_i - result handshake
//            out_class_o, out_err_o, out_steps_o - result fields
// Revision : 1.0 - initial release
// ============================================================================
module dtree_seq_ctrl #(
  parameter int NFEAT   = 7,
  parameter int NODES   = 16,
  parameter int CLASS_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we_i,
  input  logic [3:0]           cfg_addr_i,
  input  logic [27:0]          cfg_data_i,
  output logic                 cfg_ready_o,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [8*NFEAT-1:0]   feat_in_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [CLASS_W-1:0]   out_class_o,
  output logic                 out_err_o,
  output logic [4:0]           out_steps_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Feature indices at or above this value abort the walk.
  localparam logic [3:0] NFEAT_LIM = (NFEAT >= 8) ? 4'd8 : 4'(NFEAT);
  localparam logic [5:0] GUARD     = 6'(NODES);

  state_t               state_q;
  logic [3:0]           ptr_q;
  logic [4:0]           steps_q;
  logic [8*NFEAT-1:0]   feat_q;
  logic                 out_valid_q;
  logic [CLASS_W-1:0]   out_class_q;
  logic                 out_err_q;
  logic [4:0]           out_steps_q;

  logic [27:0]          table_q [NODES];

  // Node-table memory: no reset, written only while IDLE.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && cfg_we_i) begin
      table_q[cfg_addr_i] <= cfg_data_i;
    end
  end

  // Current node fields.
  logic [27:0] node_d;
  logic        leaf_d;
  logic [2:0]  idx_d;
  logic [2:0]  sel_d;
  logic [7:0]  thr_d;
  logic [3:0]  tnext_d;
  logic [3:0]  fnext_d;
  logic [4:0]  cls_d;

  assign node_d  = table_q[ptr_q];
  assign leaf_d  = node_d[27];
  assign idx_d   = node_d[26:24];
  assign sel_d   = node_d[23:21];
  assign thr_d   = node_d[20:13];
  assign tnext_d = node_d[12:9];
  assign fnext_d = node_d[8:5];
  assign cls_d   = node_d[4:0];

  // Unpack features into a fixed 8-entry view; slots beyond NFEAT read 0 and
  // are never used because such indices take the error path.
  logic [7:0] feat_arr_d [8];
  for (genvar k = 0; k < 8; k++) begin : g_feat
    if (k < NFEAT) begin : g_used
      assign feat_arr_d[k] = feat_q[8*k +: 8];
    end else begin : g_unused
      assign feat_arr_d[k] = 8'd0;
    end
  end

  // The single shared comparator.
  logic [7:0] fval_d;
  logic [7:0] shv_d;
  logic       take_t_d;
  logic       idx_bad_d;
  logic [4:0] steps_d;
  logic       guard_hit_d;

  assign fval_d      = feat_arr_d[idx_d];
  assign shv_d       = fval_d >> (3'd7 - sel_d);
  assign take_t_d    = (shv_d <= thr_d);
  assign idx_bad_d   = ({1'b0, idx_d} >= NFEAT_LIM);
  assign steps_d     = (steps_q == 5'd31) ? 5'd31 : steps_q + 5'd1;
  assign guard_hit_d = ({1'b0, steps_d} >= GUARD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= 4'd0;
      steps_q     <= 5'd0;
      feat_q      <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_err_q   <= 1'b0;
      out_steps_q <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            feat_q  <= feat_in_i;
            ptr_q   <= 4'd0;
            steps_q <= 5'd0;
            state_q <= S_WALK;
          end
        end
        S_WALK: begin
          steps_q <= steps_d;
          if (leaf_d) begin
            out_class_q <= CLASS_W'(cls_d);
            out_err_q   <= 1'b0;
            out_steps_q <= steps_d;
            state_q     <= S_DONE;
          end else if (idx_bad_d || guard_hit_d) begin
            out_class_q <= '0;
            out_err_q   <= 1'b1;
            out_steps_q <= steps_d;
            state_q     <= S_DONE;
          end else begin
            ptr_q <= take_t_d ? tnext_d : fnext_d;
          end
        end
        S_DONE: begin
          // Result fields settle on entry; valid is raised one edge later.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign cfg_ready_o = (state_q == S_IDLE);
  assign out_valid_o = out_valid_q;
  assign out_class_o = out_class_q;
  assign out_err_o   = out_err_q;
  assign out_steps_o = out_steps_q;

endmodule
`default_nettype wire

// File: tb/tb_dtree_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtree_seq_ctrl
// Purpose  : Scoreboard bench for dtree_seq_ctrl. The driver pushes the
//            hand-computed expected result when it issues a vector; the
//            monitor compares whenever out_valid is high and pops on the
//            handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dtree_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = 4'd0;
  logic [27:0] cfg_data = 28'd0;
  logic        cfg_ready;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [55:0] feat_in = 56'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_class;
  logic        out_err;
  logic [4:0]  out_steps;

  dtree_seq_ctrl #(.NFEAT(7), .NODES(16), .CLASS_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_data_i  (cfg_data),
    .cfg_ready_o (cfg_ready),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .feat_in_i   (feat_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_class_o (out_class),
    .out_err_o   (out_err),
    .out_steps_o (out_steps)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cls;
    int err;
    int steps;
    int lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   e0 = 0;
  bit   prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] node(input int leaf, input int idx, input int sel,
                                       input int thr, input int t, input int f,
                                       input int cls);
    logic [27:0] n;
    n = {leaf[0], idx[2:0], sel[2:0], thr[7:0], t[3:0], f[3:0], cls[4:0]};
    return n;
  endfunction

  function automatic exp_t mk(input int cls, input int err, input int steps, input int lat);
    exp_t e;
    e.cls = cls; e.err = err; e.steps = steps; e.lat = lat;
    return e;
  endfunction

  // Monitor: checks the head of the scoreboard every cycle the result is
  // presented, so a hold window also checks stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          if (!prev_v && q[0].lat >= 0) chk("latency", cyc - e0, q[0].lat);
          chk("out_class", int'(out_class), q[0].cls);
          chk("out_err", int'(out_err), q[0].err);
          chk("out_steps", int'(out_steps), q[0].steps);
          chk("in_ready_done", int'(in_ready), 0);
          chk("cfg_ready_done", int'(cfg_ready), 0);
          if (out_ready) void'(q.pop_front());
        end
      end
      prev_v = out_valid;
    end
  end

  task automatic cfg_write(input int addr, input logic [27:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = addr[3:0]; cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [55:0] f, input exp_t e, input bit expect_out,
                      input bit with_cfg, input int caddr, input logic [27:0] cdata);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    if (expect_out) q.push_back(e);
    feat_in = f; in_valid = 1'b1;
    if (with_cfg) begin
      cfg_we = 1'b1; cfg_addr = caddr[3:0]; cfg_data = cdata;
    end
    @(posedge clk);
    #1 e0 = cyc;
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || !in_ready) chk("result_timeout", 0, 1);
  endtask

  function automatic logic [55:0] fv(input int k, input int v);
    logic [55:0] x;
    x = 56'h01_23_45_67_89_AB_CD;
    x[8*k +: 8] = v[7:0];
    return x;
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_class", int'(out_class), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_out_steps", int'(out_steps), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single leaf at root: class 5, one step, valid two edges after accept
    cfg_write(0, node(1, 0, 0, 0, 0, 0, 5));
    send(56'h0, mk(5, 0, 1, 2), 1'b1, 1'b0, 0, 28'd0);
    wait_idle();

    // Two-level tree on feature 6 with sel=2 (shift right by 5)
    cfg_write(0, node(0, 6, 2, 0, 1, 2, 0));
    cfg_write(1, node(1, 0, 0, 0, 0, 0, 165 & 31));
    cfg_write(2, node(1, 0, 0, 0, 0, 0, 25));
    send(fv(6, 8'h1F), mk(5, 0, 2, 3), 1'b1, 1'b0, 0, 28'd0);
    wait_idle();
    send(fv(6, 8'h20), mk(25, 0, 2, 3), 1'b1, 1'b0, 0, 28'd0);
    wait_idle();

    // sel=7 means no shift; threshold equality takes the true branch
    cfg_write(0, node(0, 0, 7, 8'h80, 1, 2, 0));
    send(fv(0, 8'h80), mk(5, 0, 2, 3), 1'b1, 1'b0, 0, 28'd0);
    wait_idle();
    send(fv(0, 8'h81), mk(25, 0, 2, 3), 1'b1, 1'b0, 0, 28'd0);
    wait_idle();

    // Three-visit chain 0 -> 3 -> 4(leaf 17)
    cfg_write(0, node(0, 1, 7, 8'h10, 3, 1, 0));
    cfg_write(3, node(0, 2, 4, 8'h03, 2, 4, 0));
    cfg_write(4, node(1, 0, 0, 0, 0, 0, 17));
    // f1=0x05 <= 0x10 -> node 3; f2=0xF0>>3=0x1E > 3 -> node 4
    send({fv(1, 8'h05)} & ~56'h00_00_00_00_FF_00_00 | 56'h00_00_00_00_F0_00_00,
         mk(17, 0, 3, 4), 1'b1, 1'b0, 0, 28'd0);
    wait_idle();

    // Feature index out of range
    cfg_write(0, node(0, 7, 0, 0, 1, 1, 9));
    send(56'h0, mk(0, 1, 1, 2), 1'b1, 1'b0, 0, 28'd0);
    wait_idle();

    // Self loop hits the guard
    cfg_write(0, node(0, 0, 0, 0, 0, 0, 3));
    send(56'h0, mk(0, 1, 16, 17), 1'b1, 1'b0, 0, 28'd0);
    wait_idle();

    // Table write and accept on the same edge: walk sees the new entry
    send(56'h0, mk(9, 0, 1, 2), 1'b1, 1'b1, 0, node(1, 0, 0, 0, 0, 0, 9));
    wait_idle();

    // Hold in DONE with out_ready low; a write in that window is dropped
    cfg_write(0, node(1, 0, 0, 0, 0, 0, 21));
    out_ready = 1'b0;
    send(56'h0, mk(21, 0, 1, 2), 1'b1, 1'b0, 0, 28'd0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hold_valid_seen", int'(out_valid), 1);
    repeat (2) @(negedge clk);
    cfg_write(0, node(1, 0, 0, 0, 0, 0, 7));
    repeat (6) @(negedge clk);
    out_ready = 1'b1;
    wait_idle();
    send(56'h0, mk(21, 0, 1, 2), 1'b1, 1'b0, 0, 28'd0);
    wait_idle();

    // Reset mid-walk abandons the transaction
    cfg_write(0, node(0, 0, 0, 0, 0, 0, 3));
    send(56'h0, mk(0, 0, 0, 0), 1'b0, 1'b0, 0, 28'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_cfg_ready", int'(cfg_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_steps", int'(out_steps), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", int'(in_ready), 1);
    cfg_write(0, node(1, 0, 0, 0, 0, 0, 12));
    send(56'h0, mk(12, 0, 1, 2), 1'b1, 1'b0, 0, 28'd0);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
